// File: rtl/ofm_writeback.sv
// Output feature map writeback: captures one pixel's worth of parallel conv outputs
// into a shadow buffer and drains it to RAM one channel per cycle.
module ofm_writeback #(
    parameter int DSP_NO    = 512,
    parameter int WIDTH     = 16,
    parameter int WOUT      = 8,
    parameter int ADDR_W    = 16,
    parameter int BASE_ADDR = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         layer_start,
    input  logic                         conv_sample,
    input  logic [WIDTH-1:0]             ofm [0:DSP_NO-1],
    output logic                         wr_en,
    output logic [ADDR_W-1:0]            wr_addr,
    output logic [WIDTH-1:0]             wr_data,
    output logic                         ram_feedback,
    output logic                         busy,
    output logic                         overflow_err,
    output logic [$clog2(WOUT**2):0]     pix_count
);

    localparam int TOTAL = WOUT * WOUT;
    localparam int PIX_W = $clog2(WOUT**2) + 1;
    localparam int CH_W  = (DSP_NO > 1) ? $clog2(DSP_NO) : 1;

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        DONE
    } state_t;

    state_t           state, state_next;
    logic [CH_W-1:0]  ch, ch_next;
    logic [PIX_W-1:0] pix_next;
    logic             ovf_next;
    logic             fb_next;
    logic             capture;
    logic [WIDTH-1:0] shadow [0:DSP_NO-1];

    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= IDLE;
            ch           <= '0;
            pix_count    <= '0;
            overflow_err <= 1'b0;
            ram_feedback <= 1'b0;
        end else begin
            state        <= state_next;
            ch           <= ch_next;
            pix_count    <= pix_next;
            overflow_err <= ovf_next;
            ram_feedback <= fb_next;
        end
    end

    // Shadow buffer is data-only storage; it is never cleared, only overwritten on capture.
    always_ff @(posedge clk) begin
        if (capture) begin
            shadow <= ofm;
        end
    end

    always_comb begin
        state_next = state;
        ch_next    = ch;
        pix_next   = pix_count;
        ovf_next   = overflow_err;
        fb_next    = 1'b0;
        capture    = 1'b0;

        if (layer_start) begin
            state_next = IDLE;
            ch_next    = '0;
            pix_next   = '0;
            ovf_next   = 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (conv_sample && (pix_count < PIX_W'(TOTAL))) begin
                        capture    = 1'b1;
                        ch_next    = '0;
                        state_next = DRAIN;
                    end
                end
                DRAIN: begin
                    if (ch == CH_W'(DSP_NO - 1)) begin
                        pix_next = pix_count + PIX_W'(1);
                        ch_next  = '0;
                        // A sample landing on the final channel chains straight into the next drain.
                        if (pix_next == PIX_W'(TOTAL)) begin
                            state_next = DONE;
                            fb_next    = 1'b1;
                        end else if (conv_sample) begin
                            capture    = 1'b1;
                            state_next = DRAIN;
                        end else begin
                            state_next = IDLE;
                        end
                    end else begin
                        ch_next = ch + CH_W'(1);
                        if (conv_sample) begin
                            ovf_next = 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_next = DONE;
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    always_comb begin
        busy    = (state == DRAIN);
        wr_en   = busy;
        wr_addr = '0;
        wr_data = '0;
        if (busy) begin
            wr_addr = ADDR_W'(BASE_ADDR) + ADDR_W'(pix_count) * ADDR_W'(DSP_NO) + ADDR_W'(ch);
            wr_data = shadow[ch];
        end
    end

endmodule

// File: tb/tb_ofm_writeback.sv
// Directed self-checking bench for ofm_writeback with DSP_NO=4, WOUT=2, BASE_ADDR=0x100.
module tb_ofm_writeback;

    logic        clk;
    logic        rst;
    logic        layer_start;
    logic        conv_sample;
    logic [15:0] ofm [0:3];
    logic        wr_en;
    logic [15:0] wr_addr;
    logic [15:0] wr_data;
    logic        ram_feedback;
    logic        busy;
    logic        overflow_err;
    logic [2:0]  pix_count;

    int n_checks = 0;
    int n_fail   = 0;

    ofm_writeback #(
        .DSP_NO(4), .WIDTH(16), .WOUT(2), .ADDR_W(16), .BASE_ADDR(32'h100)
    ) dut (
        .clk(clk), .rst(rst), .layer_start(layer_start), .conv_sample(conv_sample),
        .ofm(ofm), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .ram_feedback(ram_feedback), .busy(busy), .overflow_err(overflow_err),
        .pix_count(pix_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs are driven and outputs sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_write(input string tag, input logic [15:0] addr, input logic [15:0] data);
        check_output({tag, " wr_en"}, 32'(wr_en), 32'd1);
        check_output({tag, " wr_addr"}, 32'(wr_addr), 32'(addr));
        check_output({tag, " wr_data"}, 32'(wr_data), 32'(data));
    endtask

    task automatic check_quiet(input string tag);
        check_output({tag, " wr_en"}, 32'(wr_en), 32'd0);
        check_output({tag, " busy"}, 32'(busy), 32'd0);
    endtask

    // Presents one pixel for a single cycle, leaving the bench in the first drain cycle.
    task automatic apply_stimulus(input logic [15:0] a, input logic [15:0] b,
                                  input logic [15:0] c, input logic [15:0] d);
        ofm[0] = a; ofm[1] = b; ofm[2] = c; ofm[3] = d;
        conv_sample = 1'b1;
        tick();
        conv_sample = 1'b0;
    endtask

    task automatic pulse_layer_start();
        layer_start = 1'b1;
        tick();
        layer_start = 1'b0;
    endtask

    initial begin
        rst = 1'b0; layer_start = 1'b0; conv_sample = 1'b0;
        for (int i = 0; i < 4; i++) ofm[i] = '0;
        tick();
        tick();
        check_output("reset wr_en", 32'(wr_en), 32'd0);
        check_output("reset wr_addr", 32'(wr_addr), 32'd0);
        check_output("reset wr_data", 32'(wr_data), 32'd0);
        check_output("reset busy", 32'(busy), 32'd0);
        check_output("reset feedback", 32'(ram_feedback), 32'd0);
        check_output("reset overflow", 32'(overflow_err), 32'd0);
        check_output("reset pix_count", 32'(pix_count), 32'd0);
        rst = 1'b1;
        tick();

        $display("[TB] single pixel");
        apply_stimulus(16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD);
        check_write("single ch0", 16'h100, 16'hAAAA);
        check_output("single busy", 32'(busy), 32'd1);
        tick(); check_write("single ch1", 16'h101, 16'hBBBB);
        tick(); check_write("single ch2", 16'h102, 16'hCCCC);
        tick(); check_write("single ch3", 16'h103, 16'hDDDD);
        tick();
        check_quiet("single after");
        check_output("single pix_count", 32'(pix_count), 32'd1);

        $display("[TB] full layer");
        pulse_layer_start();
        check_output("layer_start pix_count", 32'(pix_count), 32'd0);
        for (int p = 0; p < 4; p++) begin
            apply_stimulus(16'(16'h1000 * (p + 1)), 16'(16'h1000 * (p + 1) + 1),
                           16'(16'h1000 * (p + 1) + 2), 16'(16'h1000 * (p + 1) + 3));
            for (int k = 0; k < 4; k++) begin
                if (k > 0) tick();
                check_write("layer write", 16'(16'h100 + 4 * p + k), 16'(16'h1000 * (p + 1) + k));
                check_output("layer no feedback", 32'(ram_feedback), 32'd0);
            end
            tick();
            check_quiet("layer gap");
            check_output("layer feedback", 32'(ram_feedback), (p == 3) ? 32'd1 : 32'd0);
            check_output("layer pix_count", 32'(pix_count), 32'(p + 1));
            for (int g = 0; g < 5; g++) tick();
        end
        check_output("layer feedback single pulse", 32'(ram_feedback), 32'd0);
        apply_stimulus(16'hEEEE, 16'hEEEE, 16'hEEEE, 16'hEEEE);
        for (int k = 0; k < 4; k++) begin
            check_quiet("done ignores sample");
            tick();
        end
        check_output("done overflow", 32'(overflow_err), 32'd0);
        check_output("done pix_count", 32'(pix_count), 32'd4);

        $display("[TB] layer_start in DONE");
        pulse_layer_start();
        check_output("restart pix_count", 32'(pix_count), 32'd0);
        check_output("restart feedback", 32'(ram_feedback), 32'd0);

        $display("[TB] back-to-back");
        apply_stimulus(16'h0A01, 16'h0A02, 16'h0A03, 16'h0A04);
        check_write("b2b ch0", 16'h100, 16'h0A01);
        tick(); check_write("b2b ch1", 16'h101, 16'h0A02);
        tick(); check_write("b2b ch2", 16'h102, 16'h0A03);
        tick(); check_write("b2b ch3", 16'h103, 16'h0A04);
        apply_stimulus(16'h0B01, 16'h0B02, 16'h0B03, 16'h0B04);
        check_write("b2b second ch0", 16'h104, 16'h0B01);
        tick(); check_write("b2b second ch1", 16'h105, 16'h0B02);
        tick(); check_write("b2b second ch2", 16'h106, 16'h0B03);
        tick(); check_write("b2b second ch3", 16'h107, 16'h0B04);
        tick();
        check_quiet("b2b after");
        check_output("b2b overflow", 32'(overflow_err), 32'd0);
        check_output("b2b pix_count", 32'(pix_count), 32'd2);

        $display("[TB] overflow");
        pulse_layer_start();
        apply_stimulus(16'h0C01, 16'h0C02, 16'h0C03, 16'h0C04);
        check_write("ovf ch0", 16'h100, 16'h0C01);
        tick(); check_write("ovf ch1", 16'h101, 16'h0C02);
        apply_stimulus(16'h0D01, 16'h0D02, 16'h0D03, 16'h0D04);
        check_write("ovf ch2 unaffected", 16'h102, 16'h0C03);
        check_output("ovf flag set", 32'(overflow_err), 32'd1);
        tick(); check_write("ovf ch3 unaffected", 16'h103, 16'h0C04);
        tick();
        check_quiet("ovf after");
        check_output("ovf pix_count", 32'(pix_count), 32'd1);
        tick(); tick();
        check_quiet("ovf dropped sample");
        check_output("ovf flag sticky", 32'(overflow_err), 32'd1);
        apply_stimulus(16'h0E01, 16'h0E02, 16'h0E03, 16'h0E04);
        check_write("ovf next ch0", 16'h104, 16'h0E01);
        tick(); tick(); tick();
        check_write("ovf next ch3", 16'h107, 16'h0E04);
        tick();
        check_output("ovf next pix_count", 32'(pix_count), 32'd2);

        $display("[TB] reset mid-drain");
        apply_stimulus(16'h0F01, 16'h0F02, 16'h0F03, 16'h0F04);
        check_write("rst ch0", 16'h108, 16'h0F01);
        tick();
        check_write("rst ch1", 16'h109, 16'h0F02);
        rst = 1'b0;
        layer_start = 1'b1;
        conv_sample = 1'b1;
        tick();
        rst = 1'b1;
        layer_start = 1'b0;
        conv_sample = 1'b0;
        check_quiet("rst abort");
        check_output("rst wr_addr", 32'(wr_addr), 32'd0);
        check_output("rst wr_data", 32'(wr_data), 32'd0);
        check_output("rst overflow", 32'(overflow_err), 32'd0);
        check_output("rst pix_count", 32'(pix_count), 32'd0);
        check_output("rst feedback", 32'(ram_feedback), 32'd0);
        tick();
        check_quiet("rst stays idle");
        apply_stimulus(16'h1101, 16'h1102, 16'h1103, 16'h1104);
        check_write("rst fresh ch0", 16'h100, 16'h1101);

        $display("[TB] layer_start with sample mid-drain");
        tick();
        layer_start = 1'b1;
        conv_sample = 1'b1;
        tick();
        layer_start = 1'b0;
        conv_sample = 1'b0;
        check_quiet("ls abort");
        check_output("ls overflow", 32'(overflow_err), 32'd0);
        check_output("ls pix_count", 32'(pix_count), 32'd0);
        tick();
        check_quiet("ls sample dropped");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
